// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: drives pipeline register
// enables/flushes and PC control, latches halt, and counts stall cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned STALL_W = 16,
  parameter logic [5:0]  J_OP    = 6'h02,
  parameter logic [5:0]  JAL_OP  = 6'h03
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic [31:0]        IF_instr,
  input  logic               ID_dread,
  input  logic               ID_JR,
  input  logic [4:0]         ID_rt,
  input  logic               EX_BEQ,
  input  logic               EX_BNE,
  input  logic               EX_zero,
  input  logic               EX_dread,
  input  logic               EX_dwrite,
  input  logic               EX_halt,
  input  logic               MEM_halt,
  output logic               IF_EN,
  output logic               ID_EN,
  output logic               EX_EN,
  output logic               MEM_EN,
  output logic               IF_FLUSH,
  output logic               ID_FLUSH,
  output logic               EX_FLUSH,
  output logic               MEM_FLUSH,
  output logic               pc_en,
  output logic [1:0]         pc_sel,
  output logic               halt,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DWAIT  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               halt_r;
  logic [STALL_W-1:0] stall_cnt_r;

  logic mem_op_s;
  logic adv_s;
  logic taken_s;
  logic luse_s;
  logic jump_s;
  logic instr_unused_s;

  assign mem_op_s = EX_dread | EX_dwrite;
  assign adv_s    = ihit & (~mem_op_s | dhit);
  assign taken_s  = (EX_BEQ & EX_zero) | (EX_BNE & ~EX_zero);
  assign luse_s   = ID_dread & (ID_rt != 5'd0) &
                    ((ID_rt == IF_instr[25:21]) | (ID_rt == IF_instr[20:16]));
  assign jump_s   = (IF_instr[31:26] == J_OP) | (IF_instr[31:26] == JAL_OP);
  // Immediate/function field plays no part in hazard decisions.
  assign instr_unused_s = ^IF_instr[15:0];

  // Next-state and combinational enable/flush/PC decode.
  always_comb begin
    state_nxt_s = state_r;
    IF_EN       = 1'b0;
    ID_EN       = 1'b0;
    EX_EN       = 1'b0;
    MEM_EN      = 1'b0;
    IF_FLUSH    = 1'b0;
    ID_FLUSH    = 1'b0;
    EX_FLUSH    = 1'b0;
    MEM_FLUSH   = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 2'b00;
    if (!nRST) begin
      // Clear every pipeline register while reset is held.
      IF_FLUSH    = 1'b1;
      ID_FLUSH    = 1'b1;
      EX_FLUSH    = 1'b1;
      MEM_FLUSH   = 1'b1;
      state_nxt_s = RUN;
    end else begin
      case (state_r)
        RUN, DWAIT: begin
          if (state_r == RUN) begin
            if (mem_op_s & ~dhit) begin
              state_nxt_s = DWAIT;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            if (dhit) begin
              state_nxt_s = RUN;
            end else begin
              state_nxt_s = DWAIT;
            end
          end

          if (mem_op_s & dhit & ~ihit) begin
            // Data access consumed; the fetch side waits.
            MEM_EN   = 1'b1;
            EX_FLUSH = 1'b1;
          end else if (!adv_s) begin
            MEM_FLUSH = 1'b1;
          end else begin
            IF_EN  = 1'b1;
            ID_EN  = 1'b1;
            EX_EN  = 1'b1;
            MEM_EN = 1'b1;
            if (taken_s) begin
              IF_FLUSH = 1'b1;
              ID_FLUSH = 1'b1;
              EX_FLUSH = 1'b1;
              pc_sel   = 2'b10;
              pc_en    = 1'b1;
            end else if (EX_halt) begin
              IF_FLUSH = 1'b1;
              ID_FLUSH = 1'b1;
              EX_FLUSH = 1'b1;
            end else if (ID_JR) begin
              IF_FLUSH = 1'b1;
              ID_FLUSH = 1'b1;
              pc_sel   = 2'b11;
              pc_en    = 1'b1;
            end else if (luse_s) begin
              // Hold IF/ID, inject a bubble into ID/EX.
              IF_EN    = 1'b0;
              ID_FLUSH = 1'b1;
            end else if (jump_s) begin
              IF_FLUSH = 1'b1;
              pc_sel   = 2'b01;
              pc_en    = 1'b1;
            end else begin
              pc_sel = 2'b00;
              pc_en  = 1'b1;
            end
          end
        end
        HALTED: begin
          state_nxt_s = HALTED;
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase

      if (MEM_halt) begin
        state_nxt_s = HALTED;
      end else begin
        state_nxt_s = state_nxt_s;
      end
    end
  end

  // State register with sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= RUN;
      halt_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      halt_r  <= (state_nxt_s == HALTED);
    end
  end

  // Saturating stall-cycle counter, frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_r <= '0;
    end else if ((state_r != HALTED) && !pc_en && (stall_cnt_r != {STALL_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign halt      = halt_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (narrow counter to reach saturation).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned SW = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dhit;
  logic [31:0]   IF_instr;
  logic          ID_dread, ID_JR;
  logic [4:0]    ID_rt;
  logic          EX_BEQ, EX_BNE, EX_zero, EX_dread, EX_dwrite, EX_halt, MEM_halt;
  logic          IF_EN, ID_EN, EX_EN, MEM_EN;
  logic          IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH;
  logic          pc_en, halt;
  logic [1:0]    pc_sel;
  logic [SW-1:0] stall_cnt;
  logic [10:0]   outs;

  int n_pass = 0;
  int n_total = 0;

  // {IF_EN,ID_EN,EX_EN,MEM_EN, IF_FL,ID_FL,EX_FL,MEM_FL, pc_en, pc_sel}
  localparam logic [10:0] V_RST    = 11'b0000_1111_0_00;
  localparam logic [10:0] V_NORM   = 11'b1111_0000_1_00;
  localparam logic [10:0] V_STALL  = 11'b0000_0001_0_00;
  localparam logic [10:0] V_DDONE  = 11'b0001_0010_0_00;
  localparam logic [10:0] V_LUSE   = 11'b0111_0100_0_00;
  localparam logic [10:0] V_BR     = 11'b1111_1110_1_10;
  localparam logic [10:0] V_JR     = 11'b1111_1100_1_11;
  localparam logic [10:0] V_J      = 11'b1111_1000_1_01;
  localparam logic [10:0] V_EXHALT = 11'b1111_1110_0_00;
  localparam logic [10:0] V_OFF    = 11'b0000_0000_0_00;

  assign outs = {IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH, pc_en, pc_sel};

  pipeline_hazard_ctrl #(.STALL_W(SW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .IF_instr(IF_instr),
    .ID_dread(ID_dread), .ID_JR(ID_JR), .ID_rt(ID_rt),
    .EX_BEQ(EX_BEQ), .EX_BNE(EX_BNE), .EX_zero(EX_zero), .EX_dread(EX_dread),
    .EX_dwrite(EX_dwrite), .EX_halt(EX_halt), .MEM_halt(MEM_halt),
    .IF_EN(IF_EN), .ID_EN(ID_EN), .EX_EN(EX_EN), .MEM_EN(MEM_EN),
    .IF_FLUSH(IF_FLUSH), .ID_FLUSH(ID_FLUSH), .EX_FLUSH(EX_FLUSH), .MEM_FLUSH(MEM_FLUSH),
    .pc_en(pc_en), .pc_sel(pc_sel), .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    dhit = 1'b0; IF_instr = 32'h0000_0000;
    ID_dread = 1'b0; ID_JR = 1'b0; ID_rt = 5'd0;
    EX_BEQ = 1'b0; EX_BNE = 1'b0; EX_zero = 1'b0;
    EX_dread = 1'b0; EX_dwrite = 1'b0; EX_halt = 1'b0; MEM_halt = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0;
    idle_inputs();
    #2;
    chk("rst_outs", {5'd0, outs}, {5'd0, V_RST});
    chk("rst_halt", {15'd0, halt}, 16'd0);
    chk("rst_cnt", {12'd0, stall_cnt}, 16'd0);

    // Normal advance
    ihit = 1'b1; nRST = 1'b1; #1;
    chk("norm_outs", {5'd0, outs}, {5'd0, V_NORM});
    cyc();
    chk("norm_cnt", {12'd0, stall_cnt}, 16'd0);

    // Load miss: three stall cycles then dhit & ihit together
    EX_dread = 1'b1; #1;
    chk("miss_c1", {5'd0, outs}, {5'd0, V_STALL});
    cyc();
    chk("miss_c2", {5'd0, outs}, {5'd0, V_STALL});
    cyc();
    chk("miss_c3", {5'd0, outs}, {5'd0, V_STALL});
    cyc();
    dhit = 1'b1; #1;
    chk("miss_done", {5'd0, outs}, {5'd0, V_NORM});
    cyc();
    chk("miss_cnt", {12'd0, stall_cnt}, 16'd3);

    // Store completes while fetch pending
    EX_dread = 1'b0; EX_dwrite = 1'b1; dhit = 1'b1; ihit = 1'b0; #1;
    chk("ddone_outs", {5'd0, outs}, {5'd0, V_DDONE});
    cyc();
    chk("ddone_cnt", {12'd0, stall_cnt}, 16'd4);
    EX_dwrite = 1'b0; dhit = 1'b0; ihit = 1'b1; #1;
    chk("ddone_next", {5'd0, outs}, {5'd0, V_NORM});
    cyc();

    // Load-use on rs, then rt, then rt=0 (no hazard)
    ID_dread = 1'b1; ID_rt = 5'd5; IF_instr = {6'h00, 5'd5, 5'd0, 16'h1234}; #1;
    chk("luse_rs", {5'd0, outs}, {5'd0, V_LUSE});
    cyc();
    IF_instr = {6'h00, 5'd3, 5'd5, 16'h0000}; #1;
    chk("luse_rt", {5'd0, outs}, {5'd0, V_LUSE});
    cyc();
    chk("luse_cnt", {12'd0, stall_cnt}, 16'd6);
    ID_rt = 5'd0; IF_instr = 32'h0000_0000; #1;
    chk("luse_r0", {5'd0, outs}, {5'd0, V_NORM});
    cyc();
    ID_dread = 1'b0;

    // Flush priority
    EX_BEQ = 1'b1; EX_zero = 1'b1; ID_JR = 1'b1; IF_instr = {6'h02, 26'd0};
    ID_dread = 1'b1; ID_rt = 5'd0; #1;
    chk("br_wins", {5'd0, outs}, {5'd0, V_BR});
    EX_zero = 1'b0; #1;
    chk("jr_wins", {5'd0, outs}, {5'd0, V_JR});
    EX_BEQ = 1'b0; EX_BNE = 1'b1; #1;
    chk("bne_taken", {5'd0, outs}, {5'd0, V_BR});
    EX_BNE = 1'b0; ID_JR = 1'b0; #1;
    chk("j_only", {5'd0, outs}, {5'd0, V_J});
    IF_instr = {6'h03, 26'h155}; #1;
    chk("jal_only", {5'd0, outs}, {5'd0, V_J});
    EX_halt = 1'b1; #1;
    chk("ex_halt", {5'd0, outs}, {5'd0, V_EXHALT});
    idle_inputs(); #1;

    // Halt
    MEM_halt = 1'b1; #1;
    chk("pre_halt", {5'd0, outs}, {5'd0, V_NORM});
    chk("pre_halt_flag", {15'd0, halt}, 16'd0);
    cyc();
    chk("halt_flag", {15'd0, halt}, 16'd1);
    MEM_halt = 1'b0; dhit = 1'b1; EX_dread = 1'b1; #1;
    chk("halt_outs", {5'd0, outs}, {5'd0, V_OFF});
    cyc(); cyc(); cyc();
    chk("halt_outs2", {5'd0, outs}, {5'd0, V_OFF});
    chk("halt_cnt", {12'd0, stall_cnt}, 16'd6);
    chk("halt_sticky", {15'd0, halt}, 16'd1);

    // Reset pulse while halted
    nRST = 1'b0; #1;
    chk("rst2_halt", {15'd0, halt}, 16'd0);
    chk("rst2_cnt", {12'd0, stall_cnt}, 16'd0);
    chk("rst2_outs", {5'd0, outs}, {5'd0, V_RST});
    idle_inputs(); nRST = 1'b1; #1;
    chk("rst2_run", {5'd0, outs}, {5'd0, V_NORM});
    cyc();
    chk("rst2_cnt_run", {12'd0, stall_cnt}, 16'd0);

    // Saturation of the narrow counter
    ihit = 1'b0; #1;
    chk("sat_outs", {5'd0, outs}, {5'd0, V_STALL});
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_cnt", {12'd0, stall_cnt}, 16'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
